// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned BIT_CNT_W = 3;

    localparam logic              I2C_ACK          = 1'b0;
    localparam logic              I2C_NACK         = 1'b1;
    localparam logic [ADDR_W-1:0] DEV_ADDR_DEFAULT = 7'h50;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_e;

endpackage

// File: rtl/i2c_if.sv
// Pin and local-logic signals of the I2C target.
interface i2c_if;
    import i2c_pkg::*;

    logic              scl_in;
    logic              sda_in;
    logic              sda_oe;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_ready;
    logic              busy;
    logic              addr_match;

    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_oe, rx_data, rx_valid, tx_ready, busy, addr_match
    );

    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_ready, busy, addr_match
    );

endinterface

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser plus history flop; level is registered, edges derive from it.
module i2c_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic in_i,
    output logic level_o,
    output logic rise_c,
    output logic fall_c
);

    // [0] first sync stage, [1] synchronised level, [2] previous level
    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], in_i};
        end
    end

    assign level_o = sync_q[1];
    assign rise_c  = sync_q[1] & ~sync_q[2];
    assign fall_c  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/i2c_target.sv
// Byte-oriented I2C target: address match, ACK generation, write receive and read serialise.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DEV_ADDR = DEV_ADDR_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    i2c_if.slave bus
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_c, stop_c;

    i2c_sync_edge u_scl_sync (
        .clk    (clk),
        .reset  (reset),
        .in_i   (bus.scl_in),
        .level_o(scl_lvl),
        .rise_c (scl_rise),
        .fall_c (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk    (clk),
        .reset  (reset),
        .in_i   (bus.sda_in),
        .level_o(sda_lvl),
        .rise_c (sda_rise),
        .fall_c (sda_fall)
    );

    assign start_c = sda_fall & scl_lvl;
    assign stop_c  = sda_rise & scl_lvl;

    state_e               state_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [BYTE_W-1:0]    shift_q;
    logic                 rw_q;
    logic                 phase_q;
    logic                 sda_oe_q;
    logic [BYTE_W-1:0]    rx_data_q;
    logic                 rx_valid_q;
    logic                 tx_ready_q;
    logic                 busy_q;
    logic                 addr_match_q;

    // phase_q splits each ACK slot into "assert at first fall" and "leave at second fall"
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rw_q         <= 1'b0;
            phase_q      <= 1'b0;
            sda_oe_q     <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            tx_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            addr_match_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            if (start_c) begin
                state_q      <= ADDR;
                bit_cnt_q    <= '0;
                phase_q      <= 1'b0;
                sda_oe_q     <= 1'b0;
                addr_match_q <= 1'b0;
                busy_q       <= 1'b1;
            end else if (stop_c) begin
                state_q      <= IDLE;
                bit_cnt_q    <= '0;
                phase_q      <= 1'b0;
                sda_oe_q     <= 1'b0;
                addr_match_q <= 1'b0;
                busy_q       <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        busy_q <= 1'b0;
                    end
                    ADDR: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[BYTE_W-2:0], sda_lvl};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rw_q    <= sda_lvl;
                                phase_q <= 1'b0;
                                state_q <= (shift_q[ADDR_W-1:0] == DEV_ADDR) ? ADDR_ACK : IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!phase_q) begin
                                sda_oe_q     <= 1'b1;
                                addr_match_q <= 1'b1;
                                phase_q      <= 1'b1;
                            end else begin
                                phase_q <= 1'b0;
                                if (rw_q) begin
                                    tx_ready_q <= 1'b1;
                                    state_q    <= RD_DATA;
                                end else begin
                                    sda_oe_q <= 1'b0;
                                    state_q  <= WR_DATA;
                                end
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[BYTE_W-2:0], sda_lvl};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rx_data_q  <= {shift_q[BYTE_W-2:0], sda_lvl};
                                rx_valid_q <= 1'b1;
                                phase_q    <= 1'b0;
                                state_q    <= WR_ACK;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe_q <= ~phase_q;
                            phase_q  <= ~phase_q;
                            if (phase_q) begin
                                state_q <= WR_DATA;
                            end
                        end
                    end
                    RD_DATA: begin
                        // tx_data is captured while tx_ready is high; its MSB goes out immediately
                        if (tx_ready_q) begin
                            sda_oe_q  <= ~bus.tx_data[BYTE_W-1];
                            shift_q   <= {bus.tx_data[BYTE_W-2:0], 1'b0};
                            bit_cnt_q <= 3'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 3'd0) begin
                                sda_oe_q <= 1'b0;
                                state_q  <= RD_ACK;
                            end else begin
                                sda_oe_q  <= ~shift_q[BYTE_W-1];
                                shift_q   <= {shift_q[BYTE_W-2:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise && sda_lvl == I2C_NACK) begin
                            state_q <= IGNORE;
                        end else if (scl_fall) begin
                            tx_ready_q <= 1'b1;
                            state_q    <= RD_DATA;
                        end
                    end
                    IGNORE: begin
                        sda_oe_q <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sda_oe     = sda_oe_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.tx_ready   = tx_ready_q;
    assign bus.busy       = busy_q;
    assign bus.addr_match = addr_match_q;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench: bit-banged I2C master with a scoreboard for written and read bytes.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int unsigned Q = 4;

    logic clk = 1'b0;
    logic reset;
    logic scl_m, sda_m;
    logic [7:0] tx_byte;

    always #5 clk = ~clk;

    i2c_if bus();
    assign bus.scl_in  = scl_m;
    assign bus.sda_in  = sda_m & ~bus.sda_oe;
    assign bus.tx_data = tx_byte;

    i2c_target #(.DEV_ADDR(7'h50)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int rx_cnt = 0;
    int txr_cnt = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] rd_exp[$];
    logic [7:0] mon_exp;
    logic oe_seen, am_seen, busy_low_seen;

    // Monitor: scoreboards rx_valid pulses and tracks sticky observation flags
    always @(negedge clk) begin
        if (bus.sda_oe) oe_seen = 1'b1;
        if (bus.addr_match) am_seen = 1'b1;
        if (!bus.busy) busy_low_seen = 1'b1;
        if (bus.tx_ready) txr_cnt++;
        if (bus.rx_valid) begin
            rx_cnt++;
            n_cmp++;
            if (rx_exp.size() == 0) begin
                n_err++;
                $display("FAIL rx_unexpected: got rx_data=%h, expected no rx_valid", bus.rx_data);
            end else begin
                mon_exp = rx_exp.pop_front();
                if (bus.rx_data !== mon_exp) begin
                    n_err++;
                    $display("FAIL rx_data: got %h, expected %h", bus.rx_data, mon_exp);
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(2 * Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        b = bus.sda_in;
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
    endtask

    task automatic read_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tx_byte = 8'h00;
        oe_seen = 1'b0; am_seen = 1'b0; busy_low_seen = 1'b0;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(2);
        n_cmp++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_sda_oe: got %b, expected 0", bus.sda_oe); end
        n_cmp++; if (bus.rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h, expected 00", bus.rx_data); end
        n_cmp++; if (bus.rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid: got %b, expected 0", bus.rx_valid); end
        n_cmp++; if (bus.tx_ready !== 1'b0) begin n_err++; $display("FAIL reset_tx_ready: got %b, expected 0", bus.tx_ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
        n_cmp++; if (bus.addr_match !== 1'b0) begin n_err++; $display("FAIL reset_addr_match: got %b, expected 0", bus.addr_match); end
    endtask

    task automatic test_write();
        logic ack;
        int rx0 = rx_cnt;
        i2c_start();
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL wr_busy_start: got %b, expected 1", bus.busy); end
        write_byte(8'hA0);
        read_bit(ack);
        n_cmp++; if (ack !== I2C_ACK) begin n_err++; $display("FAIL wr_addr_ack: got %b, expected 0", ack); end
        n_cmp++; if (bus.addr_match !== 1'b1) begin n_err++; $display("FAIL wr_addr_match: got %b, expected 1", bus.addr_match); end
        rx_exp.push_back(8'hAA);
        write_byte(8'hAA);
        read_bit(ack);
        n_cmp++; if (ack !== I2C_ACK) begin n_err++; $display("FAIL wr_data_ack: got %b, expected 0", ack); end
        i2c_stop();
        wait_clk(Q);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_stop: got %b, expected 0", bus.busy); end
        n_cmp++; if (rx_cnt - rx0 !== 1) begin n_err++; $display("FAIL wr_rx_count: got %0d, expected 1", rx_cnt - rx0); end
        n_cmp++; if (bus.addr_match !== 1'b0) begin n_err++; $display("FAIL wr_addr_match_stop: got %b, expected 0", bus.addr_match); end
    endtask

    task automatic test_wrong_addr();
        logic ack;
        int rx0 = rx_cnt;
        oe_seen = 1'b0; am_seen = 1'b0;
        i2c_start();
        write_byte(8'hA2);
        read_bit(ack);
        n_cmp++; if (ack !== I2C_NACK) begin n_err++; $display("FAIL wa_addr_ack: got %b, expected 1", ack); end
        write_byte(8'h55);
        read_bit(ack);
        i2c_stop();
        wait_clk(Q);
        n_cmp++; if (oe_seen !== 1'b0) begin n_err++; $display("FAIL wa_sda_oe_seen: got %b, expected 0", oe_seen); end
        n_cmp++; if (am_seen !== 1'b0) begin n_err++; $display("FAIL wa_addr_match_seen: got %b, expected 0", am_seen); end
        n_cmp++; if (rx_cnt - rx0 !== 0) begin n_err++; $display("FAIL wa_rx_count: got %0d, expected 0", rx_cnt - rx0); end
    endtask

    task automatic test_read();
        logic ack;
        logic [7:0] d, e;
        int t0 = txr_cnt;
        tx_byte = 8'h3C; rd_exp.push_back(8'h3C);
        i2c_start();
        write_byte(8'hA1);
        read_bit(ack);
        n_cmp++; if (ack !== I2C_ACK) begin n_err++; $display("FAIL rd_addr_ack: got %b, expected 0", ack); end
        read_byte(d);
        e = rd_exp.pop_front();
        n_cmp++; if (d !== e) begin n_err++; $display("FAIL rd_byte0: got %h, expected %h", d, e); end
        tx_byte = 8'hC3; rd_exp.push_back(8'hC3);
        write_bit(I2C_ACK);
        read_byte(d);
        e = rd_exp.pop_front();
        n_cmp++; if (d !== e) begin n_err++; $display("FAIL rd_byte1: got %h, expected %h", d, e); end
        write_bit(I2C_NACK);
        oe_seen = 1'b0;
        read_bit(ack);
        n_cmp++; if (ack !== 1'b1 || oe_seen !== 1'b0) begin n_err++; $display("FAIL rd_release: got line=%b oe_seen=%b, expected 1/0", ack, oe_seen); end
        i2c_stop();
        wait_clk(Q);
        n_cmp++; if (txr_cnt - t0 !== 2) begin n_err++; $display("FAIL rd_tx_ready_count: got %0d, expected 2", txr_cnt - t0); end
    endtask

    task automatic test_rep_start();
        logic ack;
        logic [7:0] d, e;
        i2c_start();
        busy_low_seen = 1'b0;
        write_byte(8'hA0);
        read_bit(ack);
        rx_exp.push_back(8'h12);
        write_byte(8'h12);
        read_bit(ack);
        n_cmp++; if (bus.addr_match !== 1'b1) begin n_err++; $display("FAIL rs_addr_match_before: got %b, expected 1", bus.addr_match); end
        i2c_start();
        n_cmp++; if (bus.addr_match !== 1'b0) begin n_err++; $display("FAIL rs_addr_match_drop: got %b, expected 0", bus.addr_match); end
        n_cmp++; if (bus.rx_data !== 8'h12) begin n_err++; $display("FAIL rs_rx_data: got %h, expected 12", bus.rx_data); end
        tx_byte = 8'h96; rd_exp.push_back(8'h96);
        write_byte(8'hA1);
        read_bit(ack);
        n_cmp++; if (ack !== I2C_ACK || bus.addr_match !== 1'b1) begin n_err++; $display("FAIL rs_read_ack: got ack=%b am=%b, expected 0/1", ack, bus.addr_match); end
        read_byte(d);
        e = rd_exp.pop_front();
        n_cmp++; if (d !== e) begin n_err++; $display("FAIL rs_read_byte: got %h, expected %h", d, e); end
        write_bit(I2C_NACK);
        n_cmp++; if (busy_low_seen !== 1'b0) begin n_err++; $display("FAIL rs_busy_dropped: got busy_low_seen=%b, expected 0", busy_low_seen); end
        i2c_stop();
        wait_clk(Q);
    endtask

    task automatic test_partial_stop();
        logic ack;
        int rx0 = rx_cnt;
        i2c_start();
        write_byte(8'hA0);
        read_bit(ack);
        for (int i = 0; i < 4; i++) write_bit(i[0]);
        i2c_stop();
        wait_clk(Q);
        n_cmp++; if (rx_cnt - rx0 !== 0) begin n_err++; $display("FAIL ps_rx_count: got %0d, expected 0", rx_cnt - rx0); end
        n_cmp++; if (bus.busy !== 1'b0 || bus.sda_oe !== 1'b0 || bus.addr_match !== 1'b0) begin
            n_err++; $display("FAIL ps_idle: got busy=%b oe=%b am=%b, expected 0/0/0", bus.busy, bus.sda_oe, bus.addr_match);
        end
    endtask

    task automatic test_reset_mid();
        logic ack;
        int rx0;
        int k = 0;
        i2c_start();
        write_byte(8'hA0);
        while (bus.sda_oe !== 1'b1 && k < 20) begin wait_clk(1); k++; end
        n_cmp++; if (bus.sda_oe !== 1'b1) begin n_err++; $display("FAIL rm_ack_oe: got %b, expected 1 within 20 clk", bus.sda_oe); end
        reset = 1'b1;
        wait_clk(1);
        n_cmp++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL rm_sda_oe: got %b, expected 0", bus.sda_oe); end
        n_cmp++; if ({bus.rx_data, bus.rx_valid, bus.tx_ready, bus.busy, bus.addr_match} !== 12'h000) begin
            n_err++; $display("FAIL rm_outputs: got %h/%b/%b/%b/%b, expected 00/0/0/0/0",
                bus.rx_data, bus.rx_valid, bus.tx_ready, bus.busy, bus.addr_match);
        end
        reset = 1'b0;
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(2 * Q);
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'hA0);
        read_bit(ack);
        n_cmp++; if (ack !== I2C_ACK) begin n_err++; $display("FAIL rm_addr_ack: got %b, expected 0", ack); end
        rx_exp.push_back(8'h77);
        write_byte(8'h77);
        read_bit(ack);
        i2c_stop();
        wait_clk(Q);
        n_cmp++; if (rx_cnt - rx0 !== 1) begin n_err++; $display("FAIL rm_rx_count: got %0d, expected 1", rx_cnt - rx0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_wrong_addr();
        test_read();
        test_rep_start();
        test_partial_stop();
        test_reset_mid();
        n_cmp++; if (rx_exp.size() != 0) begin n_err++; $display("FAIL rx_leftover: got %0d pending, expected 0", rx_exp.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
